// File: rtl/multi_clip_controller.sv
// Record/playback controller for NUM_CLIPS clips sharing one sample address counter.
// Optional macro LOOP_PLAYBACK_EN: playback wraps to address 0 at the clip length instead of stopping.
module multi_clip_controller #(
  parameter int unsigned NUM_CLIPS  = 4,
  parameter int unsigned CLIP_DEPTH = 131072,
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned SEL_WIDTH  = 4
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  play_command_i,
  input  logic                  record_command_i,
  input  logic [SEL_WIDTH-1:0]  play_clip_select_i,
  input  logic [SEL_WIDTH-1:0]  record_clip_select_i,
  input  logic                  serializer_done_i,
  input  logic                  deserializer_done_i,
  output logic                  playing_o,
  output logic                  recording_o,
  output logic [SEL_WIDTH-1:0]  active_clip_o,
  output logic                  serializer_enable_o,
  output logic                  deserializer_enable_o,
  output logic [NUM_CLIPS-1:0]  memory_enable_o,
  output logic                  memory_we_o,
  output logic [ADDR_WIDTH-1:0] memory_address_o,
  output logic [ADDR_WIDTH:0]   clip_length_o
);

  typedef enum logic [1:0] {IDLE, PLAY, RECORD} state_e;

  state_e                state_q, state_d;
  logic                  play_prev_q, rec_prev_q;
  logic [SEL_WIDTH-1:0]  active_q, active_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   len_q [NUM_CLIPS];
  logic                  len_we;
  logic [ADDR_WIDTH:0]   len_wdata;
  logic                  play_edge, rec_edge;
  logic                  play_sel_ok, rec_sel_ok;
  logic [ADDR_WIDTH:0]   addr_inc, active_len, play_sel_len;

  assign play_edge   = play_command_i & ~play_prev_q;
  assign rec_edge    = record_command_i & ~rec_prev_q;
  assign play_sel_ok = 32'(play_clip_select_i) < NUM_CLIPS;
  assign rec_sel_ok  = 32'(record_clip_select_i) < NUM_CLIPS;
  // One bit wider than the address so the final write of a full clip yields CLIP_DEPTH.
  assign addr_inc    = {1'b0, addr_q} + 1'b1;

  always_comb begin
    active_len   = '0;
    play_sel_len = '0;
    for (int unsigned i = 0; i < NUM_CLIPS; i++) begin
      if (active_q == SEL_WIDTH'(i))           active_len   = len_q[i];
      if (play_clip_select_i == SEL_WIDTH'(i)) play_sel_len = len_q[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    addr_d      = addr_q;
    len_we      = 1'b0;
    len_wdata   = {1'b0, addr_q};
    memory_we_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (rec_edge && rec_sel_ok) begin
          active_d = record_clip_select_i;
          addr_d   = '0;
          state_d  = RECORD;
        end else if (play_edge && play_sel_ok && play_sel_len != '0) begin
          active_d = play_clip_select_i;
          addr_d   = '0;
          state_d  = PLAY;
        end
      end
      RECORD: begin
        memory_we_o = deserializer_done_i;
        if (rec_edge) begin
          len_we    = 1'b1;
          len_wdata = deserializer_done_i ? addr_inc : {1'b0, addr_q};
          addr_d    = '0;
          state_d   = IDLE;
        end else if (deserializer_done_i) begin
          if (addr_q == ADDR_WIDTH'(CLIP_DEPTH - 1)) begin
            len_we    = 1'b1;
            len_wdata = (ADDR_WIDTH+1)'(CLIP_DEPTH);
            addr_d    = '0;
            state_d   = IDLE;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      PLAY: begin
        if (play_edge) begin
          addr_d  = '0;
          state_d = IDLE;
        end else if (serializer_done_i) begin
          if (addr_inc == active_len) begin
            addr_d = '0;
`ifdef LOOP_PLAYBACK_EN
            state_d = PLAY;
`else
            state_d = IDLE;
`endif
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      play_prev_q <= 1'b0;
      rec_prev_q  <= 1'b0;
      active_q    <= '0;
      addr_q      <= '0;
      for (int unsigned i = 0; i < NUM_CLIPS; i++) len_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      play_prev_q <= play_command_i;
      rec_prev_q  <= record_command_i;
      active_q    <= active_d;
      addr_q      <= addr_d;
      for (int unsigned i = 0; i < NUM_CLIPS; i++)
        if (len_we && active_q == SEL_WIDTH'(i)) len_q[i] <= len_wdata;
    end
  end

  always_comb begin
    memory_enable_o = '0;
    if (state_q != IDLE)
      for (int unsigned i = 0; i < NUM_CLIPS; i++)
        if (active_q == SEL_WIDTH'(i)) memory_enable_o[i] = 1'b1;
  end

  assign playing_o             = (state_q == PLAY);
  assign recording_o           = (state_q == RECORD);
  assign serializer_enable_o   = playing_o;
  assign deserializer_enable_o = recording_o;
  assign active_clip_o         = active_q;
  assign memory_address_o      = addr_q;
  assign clip_length_o         = active_len;

endmodule

// File: tb/tb_multi_clip_controller.sv
// Scoreboard bench for multi_clip_controller (NUM_CLIPS=4, CLIP_DEPTH=8, ADDR_WIDTH=3).
module tb_multi_clip_controller;
  localparam int unsigned NC = 4, DEPTH = 8, AW = 3, SW = 4;

  logic clk = 1'b0;
  logic reset, play_cmd, rec_cmd, ser_done, deser_done;
  logic [SW-1:0] play_sel, rec_sel;
  logic playing, recording, ser_en, deser_en, we;
  logic [SW-1:0] active;
  logic [NC-1:0] mem_en;
  logic [AW-1:0] addr;
  logic [AW:0]   clen;

  int checks = 0;
  int errors = 0;
  int wr_q[$];
  int rd_q[$];

  multi_clip_controller #(.NUM_CLIPS(NC), .CLIP_DEPTH(DEPTH), .ADDR_WIDTH(AW), .SEL_WIDTH(SW)) dut (
    .clock_i(clk), .reset_i(reset), .play_command_i(play_cmd), .record_command_i(rec_cmd),
    .play_clip_select_i(play_sel), .record_clip_select_i(rec_sel),
    .serializer_done_i(ser_done), .deserializer_done_i(deser_done),
    .playing_o(playing), .recording_o(recording), .active_clip_o(active),
    .serializer_enable_o(ser_en), .deserializer_enable_o(deser_en),
    .memory_enable_o(mem_en), .memory_we_o(we), .memory_address_o(addr),
    .clip_length_o(clen));

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every write strobe and every playback sample consumes one expected address.
  always @(negedge clk) begin
    if (!reset) begin
      if (we) begin
        if (wr_q.size() == 0) check("unexpected_write_addr", int'(addr), -1);
        else check("write_addr", int'(addr), wr_q.pop_front());
      end
      if (ser_done && playing) begin
        if (rd_q.size() == 0) check("unexpected_play_addr", int'(addr), -1);
        else check("play_addr", int'(addr), rd_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_rec(input int sel);
    rec_sel = SW'(sel); rec_cmd = 1'b1; tick(); rec_cmd = 1'b0; tick();
  endtask

  task automatic pulse_play(input int sel);
    play_sel = SW'(sel); play_cmd = 1'b1; tick(); play_cmd = 1'b0; tick();
  endtask

  task automatic strobe_deser(input int n);
    for (int i = 0; i < n; i++) begin
      deser_done = 1'b1; tick(); deser_done = 1'b0; tick();
    end
  endtask

  task automatic strobe_ser(input int n);
    for (int i = 0; i < n; i++) begin
      ser_done = 1'b1; tick(); ser_done = 1'b0; tick();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_playing"}, int'(playing), 0);
    check({tag, "_recording"}, int'(recording), 0);
    check({tag, "_mem_en"}, int'(mem_en), 0);
    check({tag, "_we"}, int'(we), 0);
    check({tag, "_addr"}, int'(addr), 0);
    check({tag, "_active"}, int'(active), 0);
    check({tag, "_clen"}, int'(clen), 0);
    check({tag, "_enables"}, int'({ser_en, deser_en}), 0);
  endtask

  initial begin
    reset = 1'b1; play_cmd = 1'b0; rec_cmd = 1'b0; ser_done = 1'b0; deser_done = 1'b0;
    play_sel = '0; rec_sel = '0;
    tick(); tick();
    reset = 1'b0; tick();
    check_all_zero("reset");

    // Empty clip cannot be played.
    pulse_play(2);
    check("play_empty_playing", int'(playing), 0);
    check("play_empty_mem_en", int'(mem_en), 0);

    // Record 5 samples into clip 1.
    pulse_rec(1);
    check("rec1_recording", int'(recording), 1);
    check("rec1_deser_en", int'(deser_en), 1);
    check("rec1_mem_en", int'(mem_en), 4'b0010);
    check("rec1_active", int'(active), 1);
    for (int i = 0; i < 5; i++) wr_q.push_back(i);
    strobe_deser(5);
    pulse_rec(1);
    check("rec1_stop_recording", int'(recording), 0);
    check("rec1_stop_mem_en", int'(mem_en), 0);
    check("rec1_clen", int'(clen), 5);

    // Play clip 1 back to its stored length.
    pulse_play(1);
    check("play1_playing", int'(playing), 1);
    check("play1_ser_en", int'(ser_en), 1);
    check("play1_mem_en", int'(mem_en), 4'b0010);
    for (int i = 0; i < 5; i++) rd_q.push_back(i);
    strobe_ser(5);
`ifdef LOOP_PLAYBACK_EN
    check("play1_loop_playing", int'(playing), 1);
    check("play1_loop_addr", int'(addr), 0);
    pulse_play(1);
`endif
    check("play1_end_playing", int'(playing), 0);
    check("play1_end_mem_en", int'(mem_en), 0);

    // Clip 3 fills at depth 8; strobes 9 and 10 must not write.
    pulse_rec(3);
    for (int i = 0; i < DEPTH; i++) wr_q.push_back(i);
    strobe_deser(10);
    check("rec3_full_recording", int'(recording), 0);
    check("rec3_full_clen", int'(clen), DEPTH);
    check("rec3_active", int'(active), 3);

    // Simultaneous edges: record wins even though clip 1 is playable.
    rec_sel = '0; play_sel = SW'(1); rec_cmd = 1'b1; play_cmd = 1'b1; tick();
    rec_cmd = 1'b0; play_cmd = 1'b0; tick();
    check("both_recording", int'(recording), 1);
    check("both_playing", int'(playing), 0);
    check("both_active", int'(active), 0);
    wr_q.push_back(0); wr_q.push_back(1);
    strobe_deser(2);

    // Reset mid-record clears state and all lengths.
    reset = 1'b1; tick();
    check_all_zero("midreset");
    reset = 1'b0; tick();
    pulse_play(1);
    check("after_reset_play1", int'(playing), 0);
    pulse_play(3);
    check("after_reset_play3", int'(playing), 0);
    check("after_reset_clen", int'(clen), 0);

    // Out-of-range record select.
    pulse_rec(5);
    check("sel5_recording", int'(recording), 0);
    check("sel5_mem_en", int'(mem_en), 0);

    // Stop edge coinciding with a write: sample kept, length = address+1.
    pulse_rec(0);
    wr_q.push_back(0); wr_q.push_back(1);
    strobe_deser(2);
    wr_q.push_back(2);
    rec_cmd = 1'b1; deser_done = 1'b1; tick();
    rec_cmd = 1'b0; deser_done = 1'b0; tick();
    check("stopwr_recording", int'(recording), 0);
    check("stopwr_clen", int'(clen), 3);

    // Stop edge coinciding with a playback strobe: stop wins.
    pulse_play(0);
    check("play0_mem_en", int'(mem_en), 4'b0001);
    rd_q.push_back(0);
    strobe_ser(1);
    rd_q.push_back(1);
    play_cmd = 1'b1; ser_done = 1'b1; tick();
    play_cmd = 1'b0; ser_done = 1'b0; tick();
    check("stopplay_playing", int'(playing), 0);
    check("stopplay_addr", int'(addr), 0);

    tick(); tick();
    check("write_queue_drained", wr_q.size(), 0);
    check("play_queue_drained", rd_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
